// File: rtl/secded_decoder_engine.sv
// Memory-mastering Hamming (11,16) SECDED decoder: reads encoded words, corrects/flags, writes message+status.
// Optional macro SECDED_STATS_EN adds sec_count/ded_count outputs.
module secded_decoder_engine #(
   parameter int NUM_WORDS = 15,
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data
`ifdef SECDED_STATS_EN
   ,
   output logic [7:0]        sec_count,
   output logic [7:0]        ded_count
`endif
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE} state_t;

   // Syndrome equals the XOR of the positions of all set bits 1..15.
   function automatic logic [3:0] syndrome_f(input logic [15:0] cw);
      logic [3:0] s;
      s = 4'b0000;
      for (int k = 1; k < 16; k++) begin
         if (cw[k]) s = s ^ 4'(k);
         else       s = s;
      end
      return s;
   endfunction

   function automatic logic parity_f(input logic [15:0] cw);
      return ^cw;
   endfunction

   function automatic logic [10:0] extract_f(input logic [15:0] cw);
      return {cw[15:9], cw[7:5], cw[3]};
   endfunction

   state_t            state_r, state_nxt_s;
   logic [IDX_W-1:0]  idx_r, idx_nxt_s;
   logic [7:0]        lo_r, hi_r;
   logic [10:0]       data_r;
   logic [1:0]        flag_r;
   logic [15:0]       cw_s, fixed_s;
   logic [3:0]        syn_s;
   logic              par_s;
   logic [10:0]       dec_data_s;
   logic [1:0]        dec_flag_s;
   logic [ADDR_W-1:0] ofs_s;
   logic              done_nxt_s, rd_nxt_s, wr_nxt_s;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic [7:0]        wdata_nxt_s;

   // Combinational decode of the captured codeword.
   always_comb begin
      cw_s       = {hi_r, lo_r};
      syn_s      = syndrome_f(cw_s);
      par_s      = parity_f(cw_s);
      fixed_s    = cw_s;
      dec_flag_s = 2'b00;
      if (par_s) begin
         fixed_s    = cw_s ^ (16'h0001 << syn_s);
         dec_flag_s = 2'b01;
      end else if (syn_s != 4'd0) begin
         dec_flag_s = 2'b10;
      end else begin
         dec_flag_s = 2'b00;
      end
      dec_data_s = extract_f(fixed_s);
   end

   // Next-state logic plus next values for the registered memory-side outputs.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      done_nxt_s  = done;
      rd_nxt_s    = 1'b0;
      wr_nxt_s    = 1'b0;
      addr_nxt_s  = {ADDR_W{1'b0}};
      wdata_nxt_s = 8'h00;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = RD_LO;
               idx_nxt_s   = {IDX_W{1'b0}};
               done_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RD_LO: state_nxt_s = RD_HI;
         RD_HI: state_nxt_s = CAP;
         CAP:   state_nxt_s = DEC;
         DEC:   state_nxt_s = WR_LO;
         WR_LO: state_nxt_s = WR_HI;
         WR_HI: begin
            if (idx_r == LAST_IDX) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RD_LO;
               idx_nxt_s   = idx_r + IDX_W'(1);
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      ofs_s = ADDR_W'({idx_nxt_s, 1'b0});
      case (state_nxt_s)
         RD_LO: begin
            rd_nxt_s   = 1'b1;
            addr_nxt_s = SRC_A + ofs_s;
         end
         RD_HI: begin
            rd_nxt_s   = 1'b1;
            addr_nxt_s = SRC_A + ofs_s + ADDR_W'(1);
         end
         WR_LO: begin
            wr_nxt_s    = 1'b1;
            addr_nxt_s  = DST_A + ofs_s;
            wdata_nxt_s = dec_data_s[7:0];
         end
         WR_HI: begin
            wr_nxt_s    = 1'b1;
            addr_nxt_s  = DST_A + ofs_s + ADDR_W'(1);
            wdata_nxt_s = {flag_r, 3'b000, data_r[10:8]};
         end
         DONE:    done_nxt_s = 1'b1;
         default: done_nxt_s = done_nxt_s;
      endcase
   end

   // State, index and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         idx_r       <= {IDX_W{1'b0}};
         done        <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_addr    <= {ADDR_W{1'b0}};
         mem_wr_data <= 8'h00;
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         done        <= done_nxt_s;
         mem_rd_en   <= rd_nxt_s;
         mem_wr_en   <= wr_nxt_s;
         mem_addr    <= addr_nxt_s;
         mem_wr_data <= wdata_nxt_s;
      end
   end

   // Byte capture (read data lags the strobe by one cycle) and decode result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo_r   <= 8'h00;
         hi_r   <= 8'h00;
         data_r <= 11'd0;
         flag_r <= 2'b00;
      end else begin
         if (state_r == RD_HI) lo_r <= mem_rd_data;
         if (state_r == CAP)   hi_r <= mem_rd_data;
         if (state_r == DEC) begin
            data_r <= dec_data_s;
            flag_r <= dec_flag_s;
         end
      end
   end

`ifdef SECDED_STATS_EN
   // Saturating per-run error statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_count <= 8'd0;
         ded_count <= 8'd0;
      end else if (state_r == IDLE && start) begin
         sec_count <= 8'd0;
         ded_count <= 8'd0;
      end else if (state_r == DEC) begin
         if (dec_flag_s == 2'b01 && sec_count != 8'hFF) sec_count <= sec_count + 8'd1;
         if (dec_flag_s == 2'b10 && ded_count != 8'hFF) ded_count <= ded_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_secded_decoder_engine.sv
// Directed self-checking bench for secded_decoder_engine with a synchronous-read byte memory model.
module tb_secded_decoder_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       done;
   logic [7:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
`ifdef SECDED_STATS_EN
   logic [7:0] sec_count, ded_count;
`endif

   logic [7:0] mem [256];
   logic       tb_we = 1'b0;
   logic [7:0] tb_addr = 8'h00;
   logic [7:0] tb_data = 8'h00;

   int errors = 0;
   int checks = 0;
   int overlap = 0;
   int stray = 0;
   logic watch_wr = 1'b0;

   logic [15:0] words  [15];
   logic [7:0]  exp_lo [15];
   logic [7:0]  exp_hi [15];

   secded_decoder_engine dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
`ifdef SECDED_STATS_EN
      , .sec_count(sec_count), .ded_count(ded_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tb_we) mem[tb_addr] <= tb_data;
      else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
      if (mem_rd_en && mem_wr_en) overlap <= overlap + 1;
      if (watch_wr && mem_wr_en) stray <= stray + 1;
   end

   function automatic logic [15:0] enc(input logic [10:0] d);
      logic [15:0] c;
      c = 16'h0000;
      c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3]; c[15:9] = d[10:4];
      c[1] = ^(c & 16'hAAAA);
      c[2] = ^(c & 16'hCCCC);
      c[4] = ^(c & 16'hF0F0);
      c[8] = ^(c & 16'hFF00);
      c[0] = ^c;
      return c;
   endfunction

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      tb_addr = a; tb_data = d; tb_we = 1'b1;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic load_words();
      for (int i = 0; i < 15; i++) begin
         poke(8'(30 + 2*i), words[i][7:0]);
         poke(8'(31 + 2*i), words[i][15:8]);
      end
   endtask

   task automatic clear_dst();
      for (int a = 0; a < 30; a++) poke(8'(a), 8'hEE);
   endtask

   // Pulses start and counts rising edges until done; rp>0 re-pulses start at that cycle.
   task automatic run(input int rp, output int cyc);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 300) begin
         start = (cyc == rp);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic check_outputs(input string name);
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (mem[2*i] !== exp_lo[i] || mem[2*i+1] !== exp_hi[i]) begin
            errors++;
            $display("FAIL %s word %0d: got %h/%h expected %h/%h", name, i,
                     mem[2*i], mem[2*i+1], exp_lo[i], exp_hi[i]);
         end
      end
   endtask

   task automatic set_directed();
      words[0]  = 16'hFFFF; exp_lo[0]  = 8'hFF; exp_hi[0]  = 8'h07;
      words[1]  = 16'h0020; exp_lo[1]  = 8'h00; exp_hi[1]  = 8'h40;
      words[2]  = 16'h0003; exp_lo[2]  = 8'h00; exp_hi[2]  = 8'h80;
      words[3]  = 16'h0001; exp_lo[3]  = 8'h00; exp_hi[3]  = 8'h40;
      words[4]  = 16'h7FFF; exp_lo[4]  = 8'hFF; exp_hi[4]  = 8'h47;
      words[5]  = 16'h0000; exp_lo[5]  = 8'h00; exp_hi[5]  = 8'h00;
      words[6]  = 16'hFFFE; exp_lo[6]  = 8'hFF; exp_hi[6]  = 8'h47;
      words[7]  = 16'h8000; exp_lo[7]  = 8'h00; exp_hi[7]  = 8'h40;
      words[8]  = 16'h0018; exp_lo[8]  = 8'h01; exp_hi[8]  = 8'h80;
      words[9]  = 16'h000F; exp_lo[9]  = 8'h01; exp_hi[9]  = 8'h00;
      words[10] = 16'h020F; exp_lo[10] = 8'h01; exp_hi[10] = 8'h40;
      words[11] = 16'h060F; exp_lo[11] = 8'h31; exp_hi[11] = 8'h80;
      words[12] = 16'hDFFF; exp_lo[12] = 8'hFF; exp_hi[12] = 8'h47;
      words[13] = 16'h3FFF; exp_lo[13] = 8'hFF; exp_hi[13] = 8'h81;
      words[14] = 16'h0010; exp_lo[14] = 8'h00; exp_hi[14] = 8'h40;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 5;
      if (done !== 1'b0)          begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      if (mem_rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
      if (mem_wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
      if (mem_addr !== 8'h00)     begin errors++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
      if (mem_wr_data !== 8'h00)  begin errors++; $display("FAIL reset_wr_data: got %h expected 00", mem_wr_data); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int cyc;
      set_directed();
      clear_dst();
      load_words();
      run(0, cyc);
      checks++;
      if (cyc !== 91) begin errors++; $display("FAIL latency: got %0d expected 91", cyc); end
      check_outputs("directed");
`ifdef SECDED_STATS_EN
      checks += 2;
      if (sec_count !== 8'd8) begin errors++; $display("FAIL sec_count: got %0d expected 8", sec_count); end
      if (ded_count !== 8'd4) begin errors++; $display("FAIL ded_count: got %0d expected 4", ded_count); end
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b expected 1", done); end
   endtask

   task automatic test_random_restart();
      int cyc;
      for (int i = 0; i < 15; i++) begin
         logic [10:0] d;
         logic [15:0] c;
         int b1, b2;
         d  = 11'($urandom);
         c  = enc(d);
         b1 = $urandom_range(0, 15);
         b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
         if (i % 3 == 0) begin
            exp_lo[i] = d[7:0]; exp_hi[i] = {5'b00000, d[10:8]};
         end else if (i % 3 == 1) begin
            c[b1] = ~c[b1];
            exp_lo[i] = d[7:0]; exp_hi[i] = {5'b01000, d[10:8]};
         end else begin
            c[b1] = ~c[b1];
            c[b2] = ~c[b2];
            exp_lo[i] = {c[12:9], c[7:5], c[3]};
            exp_hi[i] = {5'b10000, c[15:13]};
         end
         words[i] = c;
      end
      clear_dst();
      load_words();
      run(40, cyc);
      checks++;
      if (cyc !== 91) begin errors++; $display("FAIL restart_ignored: got %0d cycles expected 91", cyc); end
      check_outputs("random");
   endtask

   task automatic test_reset_midrun();
      int cyc;
      set_directed();
      clear_dst();
      load_words();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      while (cyc < 45) begin @(negedge clk); cyc++; end
      reset = 1'b1;
      watch_wr = 1'b1;
      #1;
      checks += 3;
      if (done !== 1'b0)      begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
      if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en: got %b expected 0", mem_wr_en); end
      if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL midreset_rd_en: got %b expected 0", mem_rd_en); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      watch_wr = 1'b0;
      checks += 3;
      if (stray !== 0)       begin errors++; $display("FAIL midreset_writes: got %0d expected 0", stray); end
      if (mem[13] !== 8'h47) begin errors++; $display("FAIL midreset_kept: got %h expected 47", mem[13]); end
      if (mem[14] !== 8'hEE) begin errors++; $display("FAIL midreset_untouched: got %h expected EE", mem[14]); end
      run(0, cyc);
      checks++;
      if (cyc !== 91) begin errors++; $display("FAIL rerun_latency: got %0d expected 91", cyc); end
      check_outputs("rerun");
   endtask

   task automatic test_exclusive();
      checks++;
      if (overlap !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d expected 0", overlap); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_restart();
      test_reset_midrun();
      test_exclusive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
